// File: rtl/pipe_stage_arbiter.sv
// pipe_stage_arbiter
//   Round-robin arbiter that shares one asynchronous pipeline stage among
//   N_REQ four-phase req/ack producers. Incoming up_req/dn_ack are brought
//   into the clk domain by 2-flop synchronisers. One requester is selected in
//   IDLE, its token is registered onto dn_data, and the full 4-phase cycle
//   completes on both sides before the next arbitration.
//
//   Optional feature macro: ARB_TIMEOUT_EN (downstream-wait watchdog).
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   up_req       in   [N_REQ]         per-requester 4-phase request (async)
//   up_data      in   [N_REQ*DATA_W]  requester i token at [i*DATA_W +: DATA_W]
//   up_ack       out  [N_REQ]         per-requester acknowledge
//   dn_req       out                  request to shared stage
//   dn_data      out  [DATA_W]        registered token to shared stage
//   dn_ack       in                   acknowledge from shared stage (async)
//   grant        out  [N_REQ]         one-hot current owner, 0 when idle
//   busy         out                  FSM not in IDLE
//   timeout_err  out                  sticky watchdog flag
//   dbg_state_o  out  [3]             current FSM state encoding
//
// Handshake semantics (both sides, 4-phase return-to-zero):
//   req rises -> ack rises -> req falls -> ack falls. A side only changes its
//   own signal after observing the previous phase of the other side; data is
//   stable from before req rises until ack rises.
module pipe_stage_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        up_req,
  input  logic [N_REQ*DATA_W-1:0] up_data,
  output logic [N_REQ-1:0]        up_ack,
  output logic                    dn_req,
  output logic [DATA_W-1:0]       dn_data,
  input  logic                    dn_ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [2:0]              dbg_state_o
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LAUNCH      = 3'd1,
    S_WAIT_DN_ACK = 3'd2,
    S_WAIT_DN_REL = 3'd3,
    S_WAIT_UP_REL = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    req_meta_q, req_sync_q;
  logic                ack_meta_q, ack_sync_q;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                dn_req_q, dn_req_d;
  logic [N_REQ-1:0]    up_ack_q, up_ack_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   dn_data_q, dn_data_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;

  // 2-flop synchronisers for the asynchronous handshake inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      req_meta_q <= up_req;
      req_sync_q <= req_meta_q;
      ack_meta_q <= dn_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  // Round-robin pick: scan from rr_q+N down to rr_q+1 so the last hit, which
  // wins, is the first requester after the previous owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (req_sync_q[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       timeout_hit;

  // Hit on the TIMEOUT_CYC-th cycle spent in the current wait state.
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    dn_req_d  = dn_req_q;
    up_ack_d  = up_ack_q;
    grant_d   = grant_q;
    dn_data_d = dn_data_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          g_d       = pick_idx;
          grant_d   = N_REQ'(1) << pick_idx;
          dn_data_d = up_data[pick_idx*DATA_W +: DATA_W];
          state_d   = S_LAUNCH;
        end
      end
      // One cycle of dn_data set-up before dn_req rises.
      S_LAUNCH: begin
        dn_req_d = 1'b1;
        state_d  = S_WAIT_DN_ACK;
      end
      S_WAIT_DN_ACK: begin
        if (ack_sync_q) begin
          dn_req_d = 1'b0;
          state_d  = S_WAIT_DN_REL;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          timeout_d = 1'b1;
          dn_req_d  = 1'b0;
          grant_d   = '0;
          rr_d      = g_q;
          state_d   = S_IDLE;
        end
`endif
      end
      S_WAIT_DN_REL: begin
        if (!ack_sync_q) begin
          up_ack_d = N_REQ'(1) << g_q;
          state_d  = S_WAIT_UP_REL;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          timeout_d = 1'b1;
          dn_req_d  = 1'b0;
          grant_d   = '0;
          rr_d      = g_q;
          state_d   = S_IDLE;
        end
`endif
      end
      // An early-dropped request is only looked at here, so up_ack then
      // stays high for a single cycle.
      S_WAIT_UP_REL: begin
        if (!req_sync_q[g_q]) begin
          up_ack_d = '0;
          grant_d  = '0;
          rr_d     = g_q;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT_DN_ACK || state_q == S_WAIT_DN_REL) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      rr_q      <= IDX_W'(N_REQ - 1);
      dn_req_q  <= 1'b0;
      up_ack_q  <= '0;
      grant_q   <= '0;
      dn_data_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      dn_req_q  <= dn_req_d;
      up_ack_q  <= up_ack_d;
      grant_q   <= grant_d;
      dn_data_q <= dn_data_d;
    end
  end

  assign up_ack      = up_ack_q;
  assign dn_req      = dn_req_q;
  assign dn_data     = dn_data_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_stage_arbiter.sv
// Bench for pipe_stage_arbiter. Expected grants {owner index, token} are
// queued when stimulus is issued; a monitor pops one entry on every dn_req
// rising edge and compares grant/dn_data.
module tb_pipe_stage_arbiter;

  localparam int N     = 4;
  localparam int W     = 3;
  localparam int EXP_W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   up_req;
  logic [N*W-1:0] up_data;
  logic [N-1:0]   up_ack;
  logic           dn_req;
  logic [W-1:0]   dn_data;
  logic           dn_ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;
  logic [2:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit dn_auto;
  logic [W-1:0] fair_tok [8];

  pipe_stage_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_req      (up_req),
    .up_data     (up_data),
    .up_ack      (up_ack),
    .dn_req      (dn_req),
    .dn_data     (dn_data),
    .dn_ack      (dn_ack),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic wait_dn_req(input string name);
    int n = 0;
    while (dn_req !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (dn_req !== 1'b1) note_timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) note_timeout(name);
  endtask

  task automatic wait_grant(input int idx);
    int n = 0;
    while (grant[idx] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (grant[idx] !== 1'b1) note_timeout("wait_grant");
  endtask

  task automatic wait_ack_high(input int idx, input string name);
    int n = 0;
    while (up_ack[idx] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (up_ack[idx] !== 1'b1) note_timeout(name);
  endtask

  // One full upstream 4-phase transaction from requester i.
  task automatic produce(input int i, input logic [W-1:0] d);
    int n;
    @(negedge clk);
    up_data[i*W +: W] = d;
    up_req[i] = 1'b1;
    n = 0;
    while (up_ack[i] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (up_ack[i] !== 1'b1) note_timeout("produce_ack_rise");
    up_req[i] = 1'b0;
    n = 0;
    while (up_ack[i] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (up_ack[i] !== 1'b0) note_timeout("produce_ack_fall");
  endtask

  task automatic produce2(input int i);
    produce(i, fair_tok[i]);
    produce(i, fair_tok[4+i]);
  endtask

  // ---------------- downstream responder ----------------
  initial begin
    dn_ack = 1'b0;
    forever begin
      @(negedge clk);
      dn_ack = dn_auto & dn_req;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic prev;
    logic [EXP_W-1:0] e;
    logic [N-1:0] exp_grant;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dn_req === 1'b1 && prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected actual=grant %b data %b required=no launch", grant, dn_data);
        end else begin
          e = exp_q.pop_front();
          exp_grant = '0;
          exp_grant[e[4:3]] = 1'b1;
          check("mon_grant", 32'(grant), 32'(exp_grant));
          check("mon_data", 32'(dn_data), 32'(e[2:0]));
        end
      end
      prev = dn_req;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    fair_tok = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    rst     = 1'b1;
    up_req  = '0;
    up_data = '0;
    dn_auto = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dn_req", 32'(dn_req), 0);
    check("rst_up_ack", 32'(up_ack), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dn_data", 32'(dn_data), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;

    // Single request from 1, latency edge by edge.
    @(negedge clk);
    up_data[5:3] = 3'b101;
    up_req       = 4'b0010;
    exp_q.push_back({2'd1, 3'b101});
    @(posedge clk); #1; check("lat_e1_busy", 32'(busy), 0);
    @(posedge clk); #1; check("lat_e2_busy", 32'(busy), 0);
    @(posedge clk); #1; check("lat_e3_busy", 32'(busy), 1);
    check("lat_e3_dn_req", 32'(dn_req), 0);
    check("lat_e3_grant", 32'(grant), 32'h2);
    @(posedge clk); #1; check("lat_e4_dn_req", 32'(dn_req), 1);
    wait_ack_high(1, "single_ack");
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("single_ack_hold", 32'(up_ack), 32'h2);
    @(negedge clk);
    up_req = 4'b0000;
    wait_idle("single_idle");
    check("single_ack_low", 32'(up_ack), 0);
    check("single_grant_low", 32'(grant), 0);
    check("single_data_hold", 32'(dn_data), 32'h5);

    // Reset in the middle of WAIT_DN_ACK.
    dn_auto = 1'b0;
    @(negedge clk);
    up_data[11:9] = 3'b011;
    up_req        = 4'b1000;
    exp_q.push_back({2'd3, 3'b011});
    wait_dn_req("mid_dn_req");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_dn_req", 32'(dn_req), 0);
    check("midrst_up_ack", 32'(up_ack), 0);
    check("midrst_grant", 32'(grant), 0);
    check("midrst_busy", 32'(busy), 0);
    up_req = '0;
    @(negedge clk);
    rst     = 1'b0;
    dn_auto = 1'b1;
    // Requests 0 and 3 together: pointer restarts so 0 wins first.
    exp_q.push_back({2'd0, 3'b110});
    exp_q.push_back({2'd3, 3'b011});
    fork
      produce(0, 3'b110);
      produce(3, 3'b011);
    join
    wait_idle("post_rst_idle");

    // Fairness: all four requesters, two rounds each.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({2'(i), fair_tok[r*4+i]});
      end
    end
    fork
      produce2(0);
      produce2(1);
      produce2(2);
      produce2(3);
    join
    wait_idle("fair_idle");

    // Late arrivals: 2 then 1 arrive while 0 is served; 1 goes first.
    exp_q.push_back({2'd0, 3'b010});
    exp_q.push_back({2'd1, 3'b100});
    exp_q.push_back({2'd2, 3'b001});
    fork
      produce(0, 3'b010);
      begin
        wait_grant(0);
        @(negedge clk);
        produce(2, 3'b001);
      end
      begin
        wait_grant(0);
        repeat (3) @(negedge clk);
        produce(1, 3'b100);
      end
    join
    wait_idle("late_idle");

    // Early drop of up_req[3] while the stage is stalled.
    dn_auto = 1'b0;
    @(negedge clk);
    up_data[11:9] = 3'b111;
    up_req[3]     = 1'b1;
    exp_q.push_back({2'd3, 3'b111});
    wait_dn_req("early_dn_req");
    @(negedge clk);
    up_req[3] = 1'b0;
    repeat (3) @(negedge clk);
    dn_auto = 1'b1;
    wait_ack_high(3, "early_ack");
    w = 1;
    @(posedge clk); #1;
    while (up_ack[3] === 1'b1 && w < 10) begin
      w++;
      @(posedge clk); #1;
    end
    check("early_ack_width", 32'(w), 1);
    wait_idle("early_idle");
    check("early_grant_low", 32'(grant), 0);

`ifdef ARB_TIMEOUT_EN
    begin
      int n;
      bit ack_seen;
      dn_auto = 1'b0;
      @(negedge clk);
      up_data[2:0] = 3'b011;
      up_req[0]    = 1'b1;
      exp_q.push_back({2'd0, 3'b011});
      wait_dn_req("to_dn_req");
      @(negedge clk);
      up_req[0] = 1'b0;
      n = 0;
      ack_seen = 1'b0;
      while (busy === 1'b1 && n < 60) begin
        @(posedge clk); #1;
        n++;
        if (up_ack !== '0) ack_seen = 1'b1;
      end
      check("to_cycles", 32'(n), 16);
      check("to_flag", 32'(timeout_err), 1);
      check("to_dn_req", 32'(dn_req), 0);
      check("to_no_ack", 32'(ack_seen), 0);
      dn_auto = 1'b1;
    end
`else
    check("timeout_tied", 32'(timeout_err), 0);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
